// File: rtl/hd44780_pkg.sv
// Shared constants for the HD44780 character path: control codes and
// the text buffer sequencer states.
package hd44780_pkg;

  localparam logic [7:0] CHR_BS       = 8'h08;
  localparam logic [7:0] CHR_LF       = 8'h0A;
  localparam logic [7:0] CHR_FF       = 8'h0C;
  localparam logic [7:0] CHR_CR       = 8'h0D;
  localparam logic [7:0] CHR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SCROLL = 2'd2
  } textbuf_state_e;

endpackage

// File: rtl/hd44780_textbuf_mem.sv
// Character store for the text buffer: one write port, a driver lookup
// port and a scroll source port, both reads combinational.
module hd44780_textbuf_mem #(
  parameter int         COLS = 16,
  parameter int         ROWS = 2,
  parameter logic [7:0] FILL = 8'h20,
  parameter int         IW   = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [7:0]    raddr,
  output logic [7:0]    rdata,
  input  logic [IW-1:0] saddr,
  output logic [7:0]    sdata
);

  localparam int N = ROWS*COLS;

  logic [7:0] cells [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
      logic [7:0] cell_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cell_reg <= FILL;
        else if (we && (32'(waddr) == gi))
          cell_reg <= wdata;
      end
      assign cells[gi] = cell_reg;
    end
  endgenerate

  // Out-of-range lookups read as blank so the driver can scan a full 8-bit space.
  always_comb begin
    rdata = FILL;
    sdata = FILL;
    for (int k = 0; k < N; k++) begin
      if (32'(raddr) == k) rdata = cells[k];
      if (32'(saddr) == k) sdata = cells[k];
    end
  end

endmodule

// File: rtl/hd44780_textbuf.sv
// Text frame buffer in front of the HD44780 driver: interprets a byte
// stream, manages the cursor, clear/scroll sweeps and redraw requests.
module hd44780_textbuf import hd44780_pkg::*; #(
  parameter int         COLS = 16,
  parameter int         ROWS = 2,
  parameter logic [7:0] FILL = 8'h20,
  localparam int        RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int        CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [7:0]    wr_char,
  output logic          wr_ready,
  input  logic [7:0]    idataaddr,
  output logic [7:0]    idata,
  input  logic          busy,
  output logic          trg,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col
);

  localparam int N       = ROWS*COLS;
  localparam int IW      = $clog2(N+1);
  localparam int SRC_LIM = (ROWS-1)*COLS;

  textbuf_state_e state_reg, state_next;
  logic [RW-1:0]  row_reg, row_next;
  logic [CW-1:0]  col_reg, col_next;
  logic [IW-1:0]  i_reg, i_next;
  logic           dirty_reg, dirty_next;
  logic           trg_reg, trg_next;

  logic           mem_we;
  logic [IW-1:0]  mem_waddr;
  logic [7:0]     mem_wdata;
  logic [7:0]     src_data;
  logic [IW-1:0]  cur_idx;
  logic [IW-1:0]  src_idx;
  logic           last_col, last_row, last_cell;

  assign cur_idx   = IW'(32'(row_reg)*COLS + 32'(col_reg));
  assign src_idx   = IW'(32'(i_reg) + COLS);
  assign last_col  = (col_reg == CW'(COLS-1));
  assign last_row  = (row_reg == RW'(ROWS-1));
  assign last_cell = (i_reg == IW'(N-1));

  hd44780_textbuf_mem #(
    .COLS (COLS),
    .ROWS (ROWS),
    .FILL (FILL),
    .IW   (IW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (idataaddr),
    .rdata (idata),
    .saddr (src_idx),
    .sdata (src_data)
  );

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    i_next     = i_reg;
    dirty_next = dirty_reg;
    trg_next   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cur_idx;
    mem_wdata  = FILL;
    case (state_reg)
      ST_IDLE: begin
        // Holding off on trg_reg keeps requests apart until busy is seen afresh.
        trg_next = dirty_reg && !busy && !trg_reg;
        if (trg_next) dirty_next = 1'b0;
        if (wr_valid) begin
          if (wr_char >= CHR_PRINT_LO && wr_char <= CHR_PRINT_HI) begin
            mem_we     = 1'b1;
            mem_wdata  = wr_char;
            dirty_next = 1'b1;
            if (!last_col) begin
              col_next = col_reg + CW'(1);
            end else begin
              col_next = '0;
              if (!last_row) row_next = row_reg + RW'(1);
              else begin
                state_next = ST_SCROLL;
                i_next     = '0;
              end
            end
          end else begin
            case (wr_char)
              CHR_CR: col_next = '0;
              CHR_LF: begin
                col_next = '0;
                if (!last_row) row_next = row_reg + RW'(1);
                else begin
                  state_next = ST_SCROLL;
                  i_next     = '0;
                end
              end
              CHR_FF: begin
                row_next   = '0;
                col_next   = '0;
                state_next = ST_CLEAR;
                i_next     = '0;
              end
              CHR_BS: begin
                if (col_reg != '0) begin
                  col_next   = col_reg - CW'(1);
                  mem_we     = 1'b1;
                  mem_waddr  = cur_idx - IW'(1);
                  dirty_next = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR, ST_SCROLL: begin
        mem_we    = 1'b1;
        mem_waddr = i_reg;
        if (state_reg == ST_SCROLL && 32'(i_reg) < SRC_LIM) mem_wdata = src_data;
        if (last_cell) begin
          state_next = ST_IDLE;
          dirty_next = 1'b1;
          i_next     = '0;
        end else begin
          i_next = i_reg + IW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      i_reg     <= '0;
      dirty_reg <= 1'b1;
      trg_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      i_reg     <= i_next;
      dirty_reg <= dirty_next;
      trg_reg   <= trg_next;
    end
  end

  assign wr_ready = (state_reg == ST_IDLE);
  assign trg      = trg_reg;
  assign cur_row  = row_reg;
  assign cur_col  = col_reg;

endmodule

// File: tb/tb_hd44780_textbuf.sv
// Bench for hd44780_textbuf: fixed vector table, hand sequences for the
// sweep corners, and random traffic against an array-based screen model.
module tb_hd44780_textbuf;

  localparam int         ROWS = 2;
  localparam int         COLS = 16;
  localparam int         N    = ROWS*COLS;
  localparam logic [7:0] FILL = 8'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic [7:0] idataaddr;
  logic [7:0] idata;
  logic       busy;
  logic       trg;
  logic [0:0] cur_row;
  logic [3:0] cur_col;

  hd44780_textbuf #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_char   (wr_char),
    .wr_ready  (wr_ready),
    .idataaddr (idataaddr),
    .idata     (idata),
    .busy      (busy),
    .trg       (trg),
    .cur_row   (cur_row),
    .cur_col   (cur_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int tx     = 0;

  // trg pulse monitor
  int trg_count   = 0;
  bit prev_trg    = 1'b0;
  bit consec_seen = 1'b0;
  always @(negedge clk) begin
    if (trg) trg_count++;
    if (trg && prev_trg) consec_seen = 1'b1;
    prev_trg = trg;
  end

  // Screen model: a flat array plus cursor, updated per accepted byte.
  logic [7:0] m_mem [N];
  int         m_row, m_col;

  function automatic void m_reset();
    for (int k = 0; k < N; k++) m_mem[k] = FILL;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void m_scroll();
    for (int k = 0; k < N; k++) m_mem[k] = (k + COLS < N) ? m_mem[k+COLS] : FILL;
  endfunction

  // Returns 1 when the byte starts a full-screen sweep.
  function automatic bit m_apply(input logic [7:0] c);
    bit long_op = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_mem[m_row*COLS + m_col] = c;
      if (m_col < COLS-1) m_col++;
      else if (m_row < ROWS-1) begin m_row++; m_col = 0; end
      else begin m_col = 0; m_scroll(); long_op = 1'b1; end
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h0A) begin
      m_col = 0;
      if (m_row < ROWS-1) m_row++;
      else begin m_scroll(); long_op = 1'b1; end
    end else if (c == 8'h0C) begin
      m_reset();
      long_op = 1'b1;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_mem[m_row*COLS + m_col] = FILL;
      end
    end
    return long_op;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    logic [7:0] e;
    for (int k = 0; k <= N + 2; k++) begin
      idataaddr = (k == N + 2) ? 8'hFF : 8'(k);
      #1;
      e = (k < N) ? m_mem[k] : FILL;
      if (idata !== e) begin
        if (bad == 0) $display("  %s: addr %0d read %02h want %02h", name, idataaddr, idata, e);
        bad++;
      end
    end
    chk(name, bad, 0);
  endtask

  task automatic check_cursor(input string name);
    chk({name, "_row"}, int'(cur_row), m_row);
    chk({name, "_col"}, int'(cur_col), m_col);
  endtask

  // Presents one byte, returns how many negedges wr_ready stayed low afterwards.
  task automatic send(input logic [7:0] c, output int low);
    int t = 0;
    @(negedge clk);
    while (!wr_ready && t < 200) begin @(negedge clk); t++; end
    wr_valid = 1'b1;
    wr_char  = c;
    @(negedge clk);
    wr_valid = 1'b0;
    low = 0;
    while (!wr_ready && low < 200) begin @(negedge clk); low++; end
    tx++;
    $display("tx %0d: char=%02h busy=%0d ready_low=%0d cursor=(%0d,%0d)",
             tx, c, busy, low, cur_row, cur_col);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] c;
    int         erow;
    int         ecol;
    int         idx;
    logic [7:0] val;
    int         etrg;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int  low, snap;
    bit  lng;
    logic [7:0] c;

    vecs[0]  = '{8'h58, 0, 1, 0,  8'h58, 1};  // 'X'
    vecs[1]  = '{8'h08, 0, 0, 0,  8'h20, 1};  // BS erases it
    vecs[2]  = '{8'h08, 0, 0, 0,  8'h20, 0};  // BS at column 0: nothing
    vecs[3]  = '{8'h48, 0, 1, 0,  8'h48, 1};  // 'H'
    vecs[4]  = '{8'h49, 0, 2, 1,  8'h49, 1};  // 'I'
    vecs[5]  = '{8'h0D, 0, 0, 1,  8'h49, 0};  // CR
    vecs[6]  = '{8'h0A, 1, 0, 0,  8'h48, 0};  // LF
    vecs[7]  = '{8'h5A, 1, 1, 16, 8'h5A, 1};  // 'Z'
    vecs[8]  = '{8'h01, 1, 1, 16, 8'h5A, 0};  // ignored code
    vecs[9]  = '{8'h08, 1, 0, 16, 8'h20, 1};  // BS
    vecs[10] = '{8'h08, 1, 0, 0,  8'h48, 0};  // BS at column 0, no row wrap
    vecs[11] = '{8'h7E, 1, 1, 16, 8'h7E, 1};  // highest printable
    vecs[12] = '{8'h7F, 1, 1, 17, 8'h20, 0};  // DEL ignored
    vecs[13] = '{8'h1F, 1, 1, 17, 8'h20, 0};  // below printable ignored

    rst = 1'b1; wr_valid = 1'b0; wr_char = 8'h00; idataaddr = 8'h00; busy = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_wr_ready", int'(wr_ready), 1);
    chk("reset_trg", int'(trg), 0);
    check_cursor("reset_cursor");
    check_mem("reset_mem");
    @(negedge clk);
    snap = trg_count;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_trg_once", trg_count - snap, 1);
    chk("reset_trg_low_after", int'(trg), 0);

    // Vector table
    foreach (vecs[v]) begin
      snap = trg_count;
      send(vecs[v].c, low);
      lng = m_apply(vecs[v].c);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_ready_low", v), low, 0);
      chk($sformatf("vec%0d_row", v), int'(cur_row), vecs[v].erow);
      chk($sformatf("vec%0d_col", v), int'(cur_col), vecs[v].ecol);
      idataaddr = 8'(vecs[v].idx);
      #1;
      chk($sformatf("vec%0d_cell%0d", v, vecs[v].idx), int'(idata), int'(vecs[v].val));
      chk($sformatf("vec%0d_trg", v), trg_count - snap, vecs[v].etrg);
      check_mem($sformatf("vec%0d_mem", v));
    end

    // Form feed while the driver is busy: full clear, trg held back until busy drops.
    busy = 1'b1;
    snap = trg_count;
    send(8'h0C, low);
    lng = m_apply(8'h0C);
    chk("ff_ready_low", low, N);
    check_cursor("ff_cursor");
    check_mem("ff_mem");
    repeat (5) @(negedge clk);
    chk("ff_trg_while_busy", trg_count - snap, 0);
    busy = 1'b0;
    repeat (6) @(negedge clk);
    chk("ff_trg_after_busy", trg_count - snap, 1);

    // 32 printable bytes: the last one forces a scroll.
    do_reset();
    for (int k = 0; k < N; k++) begin
      send(8'h41, low);
      lng = m_apply(8'h41);
      if (k == N-1) chk("fill_scroll_ready_low", low, N);
    end
    check_cursor("fill_cursor");
    check_mem("fill_mem");

    // Reset in the middle of a scroll.
    do_reset();
    for (int k = 0; k < N-1; k++) begin
      send(8'h42, low);
      lng = m_apply(8'h42);
    end
    @(negedge clk);
    wr_valid = 1'b1;
    wr_char  = 8'h42;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("midscroll_busy", int'(wr_ready), 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    m_reset();
    chk("midscroll_rst_ready", int'(wr_ready), 1);
    check_cursor("midscroll_rst_cursor");
    check_mem("midscroll_rst_mem");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic against the model, with busy toggling.
    for (int n = 0; n < 300; n++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 70)      c = 8'($urandom_range(32, 126));
      else if (r < 78) c = 8'h0D;
      else if (r < 86) c = 8'h0A;
      else if (r < 95) c = 8'h08;
      else if (r < 97) c = 8'h0C;
      else             c = 8'($urandom_range(128, 255));
      busy = 1'($urandom_range(0, 1));
      send(c, low);
      lng = m_apply(c);
      chk($sformatf("rand%0d_ready_low", n), low, lng ? N : 0);
      check_cursor($sformatf("rand%0d", n));
      check_mem($sformatf("rand%0d_mem", n));
    end
    busy = 1'b0;
    repeat (4) @(negedge clk);

    chk("no_back_to_back_trg", int'(consec_seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hd44780_textbuf.md
Name: hd44780_textbuf

Overview:
- Character frame buffer directly upstream of the HD44780 4-bit driver.
- Accepts a byte stream from a producer over a valid/ready handshake and interprets printable characters and a small control-code set (CR, LF, FF, BS).
- Holds ROWS×COLS characters and serves them combinationally on the driver's idataaddr/idata lookup port.
- Issues a one-cycle trg pulse to request a redraw when contents changed and the driver is not busy. Runs on the same clock as the driver.

Parameters:
- COLS, 16, characters per row
- ROWS, 2, number of rows
- FILL, 8'h20, character written on reset, clear, scroll and backspace

Ports:
- clk  in  1  block clock, same clock as the driver
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  producer has a byte on wr_char
- wr_char  in  8  byte to interpret
- wr_ready  out  1  block can accept a byte this cycle
- idataaddr  in  8  linear character index from the driver
- idata  out  8  character at idataaddr
- busy  in  1  driver busy flag
- trg  out  1  one-cycle redraw request to the driver
- cur_row  out  $clog2(ROWS)  cursor row (debug)
- cur_col  out  $clog2(COLS)  cursor column (debug)

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all cells = FILL, state = IDLE, cursor = (0,0), dirty = 1 (first frame is drawn after reset), trg = 0. wr_ready = 1 while in IDLE, including during reset.
- Addressing: index = row*COLS + col.
- Read port: idata = mem[idataaddr], combinational, zero latency. Indices ≥ ROWS*COLS return FILL.
- Handshake: a byte is accepted on a clk edge where wr_valid && wr_ready. wr_ready = (state == IDLE). Producer holds wr_char until accepted.
- States: IDLE, CLEAR, SCROLL.
- Printable byte (8'h20–8'h7E): mem[cursor] ← byte, dirty ← 1, then
  - col < COLS-1 → col+1;
  - col = COLS-1 and row < ROWS-1 → (row+1, 0);
  - col = COLS-1 and row = ROWS-1 → cursor (ROWS-1, 0), go to SCROLL.
- CR (8'h0D): col ← 0. No memory change, dirty unchanged.
- LF (8'h0A): col ← 0. If row < ROWS-1, row+1; else go to SCROLL (cursor row stays ROWS-1).
- FF (8'h0C): cursor ← (0,0), go to CLEAR.
- BS (8'h08): if col > 0, col-1 and mem[new cursor] ← FILL, dirty ← 1. At col = 0: no effect, no wrap to the previous row.
- Any other byte: accepted and discarded, no state change.
- CLEAR:
  - index counter i steps 0..ROWS*COLS-1, writing mem[i] ← FILL, one cell per cycle.
  - After the last cell: dirty ← 1, return to IDLE.
  - Exactly ROWS*COLS cycles with wr_ready = 0.
- SCROLL:
  - Counter i steps 0..ROWS*COLS-1, one cell per cycle.
  - For i < (ROWS-1)*COLS: mem[i] ← mem[i+COLS]. Otherwise mem[i] ← FILL.
  - After the last cell: dirty ← 1, return to IDLE. ROWS*COLS cycles.
  - ROWS = 1 degenerates to a row clear.
- Intermediate contents are visible on idata during CLEAR/SCROLL. trg is suppressed outside IDLE.
- trg: registered. trg = 1 for exactly one cycle on the edge where state == IDLE && dirty && !busy; dirty clears on that edge. trg never asserts on two consecutive cycles.
- Simultaneous events:
  - A byte accepted on the trg edge that modifies memory leaves dirty = 1 (set wins over clear).
  - A redraw is only requested again after busy has been observed low in a later cycle.
- Reset mid-CLEAR/SCROLL: aborts immediately to reset values; partial scroll contents are discarded.
- Widths: counter i is $clog2(ROWS*COLS+1) bits. Cursor arithmetic never wraps silently; all boundaries are handled by the rules above.

Decomposition:
- Package hd44780_pkg:
  - character constants CHR_CR, CHR_LF, CHR_FF, CHR_BS, CHR_PRINT_LO = 8'h20, CHR_PRINT_HI = 8'h7E;
  - textbuf state encoding (IDLE/CLEAR/SCROLL).
- One sub-module: hd44780_textbuf_mem.
  - ROWS*COLS × 8 register array with async reset to FILL.
  - One write port and two combinational read ports: driver lookup, and the scroll source at i+COLS.
- Cursor, FSM and trg logic stay in hd44780_textbuf.

Test Plan:
- Reset → all 32 indices read 8'h20; trg pulses once, the first cycle busy=0 after reset release; wr_ready=1.
- Send "HI" with busy=0 → idata[0]=8'h48, idata[1]=8'h49, cursor (0,2); a trg pulse follows each accepted write.
- Send 32 × "A" → after the 32nd byte, wr_ready=0 for 32 cycles; then indices 0–15 = 8'h41, 16–31 = 8'h20, cursor (1,0).
- Send "X", BS, BS → index 0 = 8'h20, cursor (0,0); the second BS changes nothing.
- Send FF with busy=1 held → wr_ready=0 for 32 cycles, all cells 8'h20, no trg; release busy → exactly one trg.
- Assert rst midway through SCROLL (cycle 10) → all cells 8'h20 and cursor (0,0) immediately, state IDLE.
